axi4_master_bridge: RTL and testbench
=====================================

// Module: axi4_master_bridge
// PURPOSE
// Converts the arbiter's simplified read/write request interface (arb_*) into AXI4 master channels (AR/R/AW/W/B).
// Sits between the request arbiter and the SoC AXI4 interconnect.
// Read and write engines are independent and may be active simultaneously; at most one outstanding transaction per direction.
// PARAMETERS
// XLEN     32  data/address width (from sysconfig.v); WSTRB width = XLEN/8
// AXI_ID   0   constant ARID/AWID driven on every transaction
// PORTS
// clk              in   1      clock; all logic on posedge
// rst              in   1      synchronous, active-high reset
// arb_read_addr_i  in   XLEN   read address; held while arb_raddr_valid_i=1
// arb_raddr_valid_i in  1      read request; held until one cycle after arb_rlast_o
// arb_rsize_i      in   4      [2:0] -> ARSIZE (bytes = 2^size); [3] ignored
// arb_rlen_i       in   8      ARLEN (beats-1)
// arb_rmask_i      in   4      unused by AXI; accepted for interface symmetry
// arb_rdata_o      out  XLEN   read beat data, valid when arb_rdata_ready_o=1
// arb_rdata_ready_o out 1      one-cycle pulse per accepted R beat
// arb_rlast_o      out  1      pulse coincident with the last beat's arb_rdata_ready_o
// arb_rerr_o       out  1      pulse with arb_rlast_o if any beat had RRESP!=OKAY or beat count != rlen+1
// arb_write_addr_i in   XLEN   write address; held while arb_write_valid_i=1
// arb_write_valid_i in  1      write request; held until one cycle after arb_wdata_ready_o
// arb_wdata_i / arb_wmask_i / arb_wsize_i / arb_wlen_i  in XLEN/4/4/8  data, lane-aligned WSTRB, AWSIZE, ignored (single beat)
// arb_wdata_ready_o out 1      one-cycle pulse when B response accepted
// arb_werr_o       out  1      pulse with arb_wdata_ready_o if BRESP!=OKAY
// axi_ar{valid,ready,addr,len,size,burst,id}, axi_r{valid,ready,data,resp,last,id}  AXI4 read channels (master side)
// axi_aw{valid,ready,addr,len,size,burst,id}, axi_w{valid,ready,data,strb,last}, axi_b{valid,ready,resp,id}  AXI4 write channels
// BEHAVIOUR
// Reset: all AXI valid/ready outputs 0, all arb_* pulse outputs 0, arb_rdata_o 0, both FSMs IDLE; in-flight transactions abandoned, no recovery.
// Constants: ARBURST=AWBURST=2'b01 (INCR), AWLEN=0, WLAST=1, IDs=AXI_ID. AXI payloads registered at request capture, stable while VALID.
// Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_DONE:
//  R_IDLE: arb_raddr_valid_i=1 -> capture addr/len/size, ARVALID<=1, go R_ADDR.
//  R_ADDR: ARVALID held until ARREADY; on handshake ARVALID<=0, RREADY<=1, beat_cnt<=0, go R_DATA.
//  R_DATA: each RVALID&RREADY -> next cycle arb_rdata_o=RDATA, arb_rdata_ready_o=1 (latency 1); beat_cnt++; OR RRESP error into err flag.
//    RLAST beat -> also arb_rlast_o=1, arb_rerr_o=(err | beat_cnt!=len); RREADY<=0; go R_DONE.
//  R_DONE: wait arb_raddr_valid_i=0 (arbiter drops it one cycle after rlast), then R_IDLE. Prevents relaunch of a stale request.
//  beat_cnt saturates at 255; beats past rlen still forwarded until RLAST.
// Write FSM W_IDLE -> W_SEND -> W_RESP -> W_DONE:
//  W_IDLE: arb_write_valid_i=1 -> capture, AWVALID<=1 and WVALID<=1 same cycle, go W_SEND.
//  W_SEND: AW and W handshakes tracked independently (aw_done/w_done); each VALID drops the cycle after its own handshake;
//    both done (incl. same-cycle) -> BREADY<=1, go W_RESP. WREADY before AWREADY is legal.
//  W_RESP: BVALID&BREADY -> BREADY<=0, next cycle arb_wdata_ready_o=1, arb_werr_o=(BRESP!=OKAY); go W_DONE.
//  W_DONE: wait arb_write_valid_i=0, then W_IDLE.
// Simultaneous read and write requests: both launched the same cycle; no ordering enforced between directions.
// RID/BID are not checked. RVALID outside R_DATA is ignored (RREADY=0).
// STRUCTURE
// XLEN from sysconfig.v; AXI constants (BURST_INCR, RESP_OKAY/EXOKAY/SLVERR/DECERR) and FSM state encodings in shared axi4_defs.vh.
// One file; read engine naturally split as sub-module axi4_master_rd (write engine stays inline).
// TESTING
// Single read len=0 addr=0x8000_0000, ARREADY after 2 cycles, RDATA=0xDEADBEEF RLAST -> one rdata_ready+rlast pulse, data 0xDEADBEEF, rerr=0.
// Burst read len=3 with RVALID gaps of 0..3 cycles -> ARLEN=3, exactly 4 rdata_ready pulses in order, rlast only on 4th.
// Write 0x1234_5678 mask 4'b0011, WREADY 3 cycles before AWREADY -> WVALID drops first, BREADY only after both, one wdata_ready pulse.
// Back-to-back reads as arbiter issues them (valid drops 1 cycle after rlast) -> exactly 2 AR handshakes, none duplicated.
// RRESP=SLVERR on beat 1 of len=1 burst, and BRESP=DECERR on write -> arb_rerr_o and arb_werr_o pulse with completion.
// rst asserted mid-burst (after 2 of 4 beats) -> next cycle all valid/ready 0, FSMs idle; fresh read then completes normally.

Source files
------------

// File: rtl/axi4_master_bridge_pkg.sv
// Shared AXI4 constants and engine state encodings for the arbiter-to-AXI4 master bridge.
package axi4_master_bridge_pkg;

   localparam int unsigned IdWidth = 4;

   localparam logic [1:0] BurstIncr  = 2'b01;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespExokay = 2'b01;
   localparam logic [1:0] RespSlverr = 2'b10;
   localparam logic [1:0] RespDecerr = 2'b11;

   typedef enum logic [1:0] {RIdle, RAddr, RData, RDone} rd_state_e;
   typedef enum logic [1:0] {WIdle, WSend, WResp, WDone} wr_state_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/axi4_master_bridge_rd.sv
// Read engine: turns one held arbiter read request into an AR burst and forwards R beats.
module axi4_master_bridge_rd
   import axi4_master_bridge_pkg::*;
#(
   parameter int unsigned        XLEN   = 32,
   parameter logic [IdWidth-1:0] AXI_ID = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [XLEN-1:0]    arb_read_addr_i,
   input  logic               arb_raddr_valid_i,
   input  logic [3:0]         arb_rsize_i,
   input  logic [7:0]         arb_rlen_i,
   output logic [XLEN-1:0]    arb_rdata_o,
   output logic               arb_rdata_ready_o,
   output logic               arb_rlast_o,
   output logic               arb_rerr_o,
   output logic               axi_arvalid,
   input  logic               axi_arready,
   output logic [XLEN-1:0]    axi_araddr,
   output logic [7:0]         axi_arlen,
   output logic [2:0]         axi_arsize,
   output logic [1:0]         axi_arburst,
   output logic [IdWidth-1:0] axi_arid,
   input  logic               axi_rvalid,
   output logic               axi_rready,
   input  logic [XLEN-1:0]    axi_rdata,
   input  logic [1:0]         axi_rresp,
   input  logic               axi_rlast
);

   rd_state_e       state_q, state_d;
   logic [XLEN-1:0] addr_q, addr_d, rdata_q, rdata_d;
   logic [7:0]      len_q, len_d, beat_q, beat_d;
   logic [2:0]      size_q, size_d;
   logic            arvalid_q, arvalid_d, rready_q, rready_d, err_q, err_d;
   logic            rdv_q, rdv_d, rlast_q, rlast_d, rerr_q, rerr_d;
   logic            unused_rsize;

   assign unused_rsize = arb_rsize_i[3];

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      size_d    = size_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      beat_d    = beat_q;
      err_d     = err_q;
      rdata_d   = rdata_q;
      rdv_d     = 1'b0;
      rlast_d   = 1'b0;
      rerr_d    = 1'b0;
      unique case (state_q)
         RIdle: if (arb_raddr_valid_i) begin
            addr_d    = arb_read_addr_i;
            len_d     = arb_rlen_i;
            size_d    = arb_rsize_i[2:0];
            arvalid_d = 1'b1;
            state_d   = RAddr;
         end
         RAddr: if (axi_arready) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            beat_d    = 8'd0;
            err_d     = 1'b0;
            state_d   = RData;
         end
         RData: if (axi_rvalid && rready_q) begin
            rdata_d = axi_rdata;
            rdv_d   = 1'b1;
            beat_d  = sat_inc8(beat_q);
            err_d   = err_q | (axi_rresp != RespOkay);
            if (axi_rlast) begin
               // beat_q is the index of this last beat, so a well-formed burst ends at len
               rlast_d  = 1'b1;
               rerr_d   = err_d | (beat_q != len_q);
               rready_d = 1'b0;
               state_d  = RDone;
            end
         end
         // The arbiter still holds its request for one cycle after rlast; do not relaunch it.
         RDone: if (!arb_raddr_valid_i) state_d = RIdle;
         default: state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RIdle;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         beat_q    <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         rdv_q     <= 1'b0;
         rlast_q   <= 1'b0;
         rerr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         size_q    <= size_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         beat_q    <= beat_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         rdv_q     <= rdv_d;
         rlast_q   <= rlast_d;
         rerr_q    <= rerr_d;
      end
   end

   assign axi_arvalid       = arvalid_q;
   assign axi_araddr        = addr_q;
   assign axi_arlen         = len_q;
   assign axi_arsize        = size_q;
   assign axi_arburst       = BurstIncr;
   assign axi_arid          = AXI_ID;
   assign axi_rready        = rready_q;
   assign arb_rdata_o       = rdata_q;
   assign arb_rdata_ready_o = rdv_q;
   assign arb_rlast_o       = rlast_q;
   assign arb_rerr_o        = rerr_q;

endmodule

// File: rtl/axi4_master_bridge.sv
// Arbiter request interface to AXI4 master bridge; independent read and write engines,
// one outstanding transaction per direction.
module axi4_master_bridge
   import axi4_master_bridge_pkg::*;
#(
   parameter int unsigned        XLEN   = 32,
   parameter logic [IdWidth-1:0] AXI_ID = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [XLEN-1:0]     arb_read_addr_i,
   input  logic                arb_raddr_valid_i,
   input  logic [3:0]          arb_rsize_i,
   input  logic [7:0]          arb_rlen_i,
   input  logic [3:0]          arb_rmask_i,
   output logic [XLEN-1:0]     arb_rdata_o,
   output logic                arb_rdata_ready_o,
   output logic                arb_rlast_o,
   output logic                arb_rerr_o,
   input  logic [XLEN-1:0]     arb_write_addr_i,
   input  logic                arb_write_valid_i,
   input  logic [XLEN-1:0]     arb_wdata_i,
   input  logic [3:0]          arb_wmask_i,
   input  logic [3:0]          arb_wsize_i,
   input  logic [7:0]          arb_wlen_i,
   output logic                arb_wdata_ready_o,
   output logic                arb_werr_o,
   output logic                axi_arvalid,
   input  logic                axi_arready,
   output logic [XLEN-1:0]     axi_araddr,
   output logic [7:0]          axi_arlen,
   output logic [2:0]          axi_arsize,
   output logic [1:0]          axi_arburst,
   output logic [IdWidth-1:0]  axi_arid,
   input  logic                axi_rvalid,
   output logic                axi_rready,
   input  logic [XLEN-1:0]     axi_rdata,
   input  logic [1:0]          axi_rresp,
   input  logic                axi_rlast,
   input  logic [IdWidth-1:0]  axi_rid,
   output logic                axi_awvalid,
   input  logic                axi_awready,
   output logic [XLEN-1:0]     axi_awaddr,
   output logic [7:0]          axi_awlen,
   output logic [2:0]          axi_awsize,
   output logic [1:0]          axi_awburst,
   output logic [IdWidth-1:0]  axi_awid,
   output logic                axi_wvalid,
   input  logic                axi_wready,
   output logic [XLEN-1:0]     axi_wdata,
   output logic [XLEN/8-1:0]   axi_wstrb,
   output logic                axi_wlast,
   input  logic                axi_bvalid,
   output logic                axi_bready,
   input  logic [1:0]          axi_bresp,
   input  logic [IdWidth-1:0]  axi_bid
);

   localparam int unsigned StrbW = XLEN / 8;

   axi4_master_bridge_rd #(
      .XLEN   (XLEN),
      .AXI_ID (AXI_ID)
   ) u_rd (
      .clk               (clk),
      .rst               (rst),
      .arb_read_addr_i   (arb_read_addr_i),
      .arb_raddr_valid_i (arb_raddr_valid_i),
      .arb_rsize_i       (arb_rsize_i),
      .arb_rlen_i        (arb_rlen_i),
      .arb_rdata_o       (arb_rdata_o),
      .arb_rdata_ready_o (arb_rdata_ready_o),
      .arb_rlast_o       (arb_rlast_o),
      .arb_rerr_o        (arb_rerr_o),
      .axi_arvalid       (axi_arvalid),
      .axi_arready       (axi_arready),
      .axi_araddr        (axi_araddr),
      .axi_arlen         (axi_arlen),
      .axi_arsize        (axi_arsize),
      .axi_arburst       (axi_arburst),
      .axi_arid          (axi_arid),
      .axi_rvalid        (axi_rvalid),
      .axi_rready        (axi_rready),
      .axi_rdata         (axi_rdata),
      .axi_rresp         (axi_rresp),
      .axi_rlast         (axi_rlast)
   );

   // Mask, wlen and response IDs carry no information for this single-ID, single-beat write master.
   logic unused_inputs;
   assign unused_inputs = ^{arb_rmask_i, arb_wsize_i[3], arb_wlen_i, axi_rid, axi_bid};

   wr_state_e        wstate_q, wstate_d;
   logic [XLEN-1:0]  awaddr_q, awaddr_d, wdata_q, wdata_d;
   logic [StrbW-1:0] wstrb_q, wstrb_d;
   logic [2:0]       awsize_q, awsize_d;
   logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic             aw_done_q, aw_done_d, w_done_q, w_done_d, bready_q, bready_d;
   logic             wdone_q, wdone_d, werr_q, werr_d;
   logic             aw_hs, w_hs;

   assign aw_hs = awvalid_q & axi_awready;
   assign w_hs  = wvalid_q & axi_wready;

   always_comb begin
      wstate_d  = wstate_q;
      awaddr_d  = awaddr_q;
      awsize_d  = awsize_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      bready_d  = bready_q;
      wdone_d   = 1'b0;
      werr_d    = 1'b0;
      unique case (wstate_q)
         WIdle: if (arb_write_valid_i) begin
            awaddr_d  = arb_write_addr_i;
            awsize_d  = arb_wsize_i[2:0];
            wdata_d   = arb_wdata_i;
            wstrb_d   = StrbW'(arb_wmask_i);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            wstate_d  = WSend;
         end
         // AW and W complete in either order; the response is only awaited once both have gone.
         WSend: begin
            if (aw_hs) begin
               awvalid_d = 1'b0;
               aw_done_d = 1'b1;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
               w_done_d = 1'b1;
            end
            if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
               bready_d = 1'b1;
               wstate_d = WResp;
            end
         end
         WResp: if (axi_bvalid && bready_q) begin
            bready_d = 1'b0;
            wdone_d  = 1'b1;
            werr_d   = (axi_bresp != RespOkay);
            wstate_d = WDone;
         end
         WDone: if (!arb_write_valid_i) wstate_d = WIdle;
         default: wstate_d = WIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wstate_q  <= WIdle;
         awaddr_q  <= '0;
         awsize_q  <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         bready_q  <= 1'b0;
         wdone_q   <= 1'b0;
         werr_q    <= 1'b0;
      end else begin
         wstate_q  <= wstate_d;
         awaddr_q  <= awaddr_d;
         awsize_q  <= awsize_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         bready_q  <= bready_d;
         wdone_q   <= wdone_d;
         werr_q    <= werr_d;
      end
   end

   assign axi_awvalid       = awvalid_q;
   assign axi_awaddr        = awaddr_q;
   assign axi_awlen         = 8'd0;
   assign axi_awsize        = awsize_q;
   assign axi_awburst       = BurstIncr;
   assign axi_awid          = AXI_ID;
   assign axi_wvalid        = wvalid_q;
   assign axi_wdata         = wdata_q;
   assign axi_wstrb         = wstrb_q;
   assign axi_wlast         = 1'b1;
   assign axi_bready        = bready_q;
   assign arb_wdata_ready_o = wdone_q;
   assign arb_werr_o        = werr_q;

endmodule

// File: tb/tb_axi4_master_bridge.sv
// Directed bench for axi4_master_bridge: the bench plays both the arbiter and the AXI4 slave.
module tb_axi4_master_bridge;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   logic        clk, rst;
   logic [31:0] arb_read_addr_i;
   logic        arb_raddr_valid_i;
   logic [3:0]  arb_rsize_i, arb_rmask_i;
   logic [7:0]  arb_rlen_i;
   logic [31:0] arb_rdata_o;
   logic        arb_rdata_ready_o, arb_rlast_o, arb_rerr_o;
   logic [31:0] arb_write_addr_i, arb_wdata_i;
   logic        arb_write_valid_i;
   logic [3:0]  arb_wmask_i, arb_wsize_i;
   logic [7:0]  arb_wlen_i;
   logic        arb_wdata_ready_o, arb_werr_o;
   logic        axi_arvalid, axi_arready;
   logic [31:0] axi_araddr;
   logic [7:0]  axi_arlen;
   logic [2:0]  axi_arsize;
   logic [1:0]  axi_arburst;
   logic [3:0]  axi_arid;
   logic        axi_rvalid, axi_rready, axi_rlast;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic [3:0]  axi_rid;
   logic        axi_awvalid, axi_awready;
   logic [31:0] axi_awaddr;
   logic [7:0]  axi_awlen;
   logic [2:0]  axi_awsize;
   logic [1:0]  axi_awburst;
   logic [3:0]  axi_awid;
   logic        axi_wvalid, axi_wready, axi_wlast;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_bvalid, axi_bready;
   logic [1:0]  axi_bresp;
   logic [3:0]  axi_bid;

   axi4_master_bridge dut (
      .clk(clk), .rst(rst),
      .arb_read_addr_i(arb_read_addr_i), .arb_raddr_valid_i(arb_raddr_valid_i),
      .arb_rsize_i(arb_rsize_i), .arb_rlen_i(arb_rlen_i), .arb_rmask_i(arb_rmask_i),
      .arb_rdata_o(arb_rdata_o), .arb_rdata_ready_o(arb_rdata_ready_o),
      .arb_rlast_o(arb_rlast_o), .arb_rerr_o(arb_rerr_o),
      .arb_write_addr_i(arb_write_addr_i), .arb_write_valid_i(arb_write_valid_i),
      .arb_wdata_i(arb_wdata_i), .arb_wmask_i(arb_wmask_i), .arb_wsize_i(arb_wsize_i),
      .arb_wlen_i(arb_wlen_i), .arb_wdata_ready_o(arb_wdata_ready_o), .arb_werr_o(arb_werr_o),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
      .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
      .axi_arid(axi_arid),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
      .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr),
      .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
      .axi_awid(axi_awid),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
      .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
      .axi_bid(axi_bid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int timeouts = 0;
   int ar_drop = 0;

   // Monitor state, written only here.
   int          ar_hs = 0, rlast_cnt = 0, rlast_idx = 0, rerr_cnt = 0;
   int          wdone_cnt = 0, werr_cnt = 0;
   logic [31:0] rd_q[$];
   logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
   logic [7:0]  cap_arlen, cap_awlen;
   logic [2:0]  cap_arsize, cap_awsize;
   logic [1:0]  cap_arburst, cap_awburst;
   logic [3:0]  cap_arid, cap_wstrb;
   logic        cap_wlast;

   always @(posedge clk) begin
      if (!rst) begin
         if (axi_arvalid && axi_arready) begin
            ar_hs       <= ar_hs + 1;
            cap_araddr  <= axi_araddr;
            cap_arlen   <= axi_arlen;
            cap_arsize  <= axi_arsize;
            cap_arburst <= axi_arburst;
            cap_arid    <= axi_arid;
         end
         if (axi_awvalid && axi_awready) begin
            cap_awaddr  <= axi_awaddr;
            cap_awlen   <= axi_awlen;
            cap_awsize  <= axi_awsize;
            cap_awburst <= axi_awburst;
         end
         if (axi_wvalid && axi_wready) begin
            cap_wdata <= axi_wdata;
            cap_wstrb <= axi_wstrb;
            cap_wlast <= axi_wlast;
         end
         if (arb_rdata_ready_o) rd_q.push_back(arb_rdata_o);
         if (arb_rlast_o) begin
            rlast_cnt <= rlast_cnt + 1;
            rlast_idx <= rd_q.size();
         end
         if (arb_rerr_o) rerr_cnt <= rerr_cnt + 1;
         if (arb_wdata_ready_o) wdone_cnt <= wdone_cnt + 1;
         if (arb_werr_o) werr_cnt <= werr_cnt + 1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_read(input logic [31:0] addr, input logic [7:0] len, input int ar_delay);
      arb_read_addr_i   = addr;
      arb_rlen_i        = len;
      arb_rsize_i       = 4'b1010;  // bit 3 must be ignored -> ARSIZE 2
      arb_rmask_i       = 4'hf;
      arb_raddr_valid_i = 1'b1;
      tick();
      for (int i = 0; i < ar_delay; i++) begin
         if (axi_arvalid !== 1'b1) ar_drop++;
         tick();
      end
      if (axi_arvalid !== 1'b1) ar_drop++;
      axi_arready = 1'b1;
      tick();
      axi_arready = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [1:0] resp, input logic last,
                            input int gap);
      int n;
      repeat (gap) tick();
      n = 0;
      while (axi_rready !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) timeouts++;
      axi_rvalid = 1'b1;
      axi_rdata  = d;
      axi_rresp  = resp;
      axi_rlast  = last;
      tick();
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      axi_rresp  = OKAY;
      axi_rdata  = '0;
   endtask

   // Arbiter behaviour: request dropped one cycle after rlast.
   task automatic end_read;
      tick();
      arb_raddr_valid_i = 1'b0;
      tick();
   endtask

   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input int aw_delay, input int w_delay,
                            input logic [1:0] bresp);
      int mx;
      mx = (aw_delay > w_delay) ? aw_delay : w_delay;
      arb_write_addr_i  = addr;
      arb_wdata_i       = data;
      arb_wmask_i       = mask;
      arb_wsize_i       = 4'd2;
      arb_wlen_i        = 8'd0;
      arb_write_valid_i = 1'b1;
      tick();
      total++;
      if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b110) begin
         bad++;
         $display("FAIL wr_launch: aw/w/b = %b, required 110", {axi_awvalid, axi_wvalid, axi_bready});
      end
      for (int c = 0; c <= mx; c++) begin
         axi_awready = (c == aw_delay);
         axi_wready  = (c == w_delay);
         tick();
         total++;
         if (axi_awvalid !== (c < aw_delay)) begin
            bad++;
            $display("FAIL awvalid_c%0d: got %b, required %b", c, axi_awvalid, c < aw_delay);
         end
         total++;
         if (axi_wvalid !== (c < w_delay)) begin
            bad++;
            $display("FAIL wvalid_c%0d: got %b, required %b", c, axi_wvalid, c < w_delay);
         end
         total++;
         if (axi_bready !== (c == mx)) begin
            bad++;
            $display("FAIL bready_c%0d: got %b, required %b", c, axi_bready, c == mx);
         end
      end
      axi_awready = 1'b0;
      axi_wready  = 1'b0;
      tick();
      axi_bvalid = 1'b1;
      axi_bresp  = bresp;
      tick();
      axi_bvalid = 1'b0;
      axi_bresp  = OKAY;
      total++;
      if (axi_bready !== 1'b0) begin
         bad++;
         $display("FAIL bready_drop: got %b, required 0", axi_bready);
      end
      tick();
      arb_write_valid_i = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b1;
      arb_read_addr_i = '0; arb_raddr_valid_i = 1'b0; arb_rsize_i = '0;
      arb_rlen_i = '0; arb_rmask_i = '0;
      arb_write_addr_i = '0; arb_write_valid_i = 1'b0; arb_wdata_i = '0;
      arb_wmask_i = '0; arb_wsize_i = '0; arb_wlen_i = '0;
      axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rdata = '0; axi_rresp = OKAY;
      axi_rlast = 1'b0; axi_rid = '0; axi_awready = 1'b0; axi_wready = 1'b0;
      axi_bvalid = 1'b0; axi_bresp = OKAY; axi_bid = '0;
      tick();
      tick();
      total++;
      if ({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} !== 5'b0) begin
         bad++;
         $display("FAIL reset_axi: valid/ready = %b, required 00000",
                  {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready});
      end
      total++;
      if ({arb_rdata_ready_o, arb_rlast_o, arb_rerr_o, arb_wdata_ready_o, arb_werr_o} !== 5'b0) begin
         bad++;
         $display("FAIL reset_pulses: got %b, required 00000",
                  {arb_rdata_ready_o, arb_rlast_o, arb_rerr_o, arb_wdata_ready_o, arb_werr_o});
      end
      total++;
      if (arb_rdata_o !== 32'h0) begin
         bad++;
         $display("FAIL reset_rdata: got %h, required 00000000", arb_rdata_o);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_read;
      int b_ar, b_rd, b_rl, b_re, b_to;
      b_ar = ar_hs; b_rd = rd_q.size(); b_rl = rlast_cnt; b_re = rerr_cnt; b_to = timeouts;
      ar_drop = 0;
      start_read(32'h8000_0000, 8'd0, 2);
      send_beat(32'hDEAD_BEEF, OKAY, 1'b1, 0);
      end_read();
      total++;
      if (ar_drop !== 0) begin bad++; $display("FAIL single_arvalid_held: drops %0d, required 0", ar_drop); end
      total++;
      if (ar_hs - b_ar !== 1) begin bad++; $display("FAIL single_ar_hs: got %0d, required 1", ar_hs - b_ar); end
      total++;
      if ({cap_araddr, cap_arlen, cap_arsize, cap_arburst, cap_arid} !==
          {32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd0}) begin
         bad++;
         $display("FAIL single_ar_payload: addr %h len %0d size %0d burst %b id %0d, required 80000000 0 2 01 0",
                  cap_araddr, cap_arlen, cap_arsize, cap_arburst, cap_arid);
      end
      total++;
      if (rd_q.size() - b_rd !== 1) begin bad++; $display("FAIL single_beats: got %0d, required 1", rd_q.size() - b_rd); end
      else begin
         total++;
         if (rd_q[b_rd] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_data: got %h, required deadbeef", rd_q[b_rd]); end
      end
      total++;
      if (rlast_cnt - b_rl !== 1 || rlast_idx !== b_rd + 1) begin
         bad++;
         $display("FAIL single_rlast: count %0d at beat %0d, required 1 at %0d", rlast_cnt - b_rl, rlast_idx, b_rd + 1);
      end
      total++;
      if (rerr_cnt - b_re !== 0) begin bad++; $display("FAIL single_rerr: got %0d, required 0", rerr_cnt - b_re); end
      total++;
      if (timeouts - b_to !== 0) begin bad++; $display("FAIL single_timeout: got %0d, required 0", timeouts - b_to); end
   endtask

   task automatic test_burst_read;
      int b_rd, b_rl, b_re;
      b_rd = rd_q.size(); b_rl = rlast_cnt; b_re = rerr_cnt;
      start_read(32'h0000_1000, 8'd3, 0);
      total++;
      if (cap_arlen !== 8'd3) begin bad++; $display("FAIL burst_arlen: got %0d, required 3", cap_arlen); end
      for (int i = 0; i < 4; i++) send_beat(32'hA5A5_0000 + i, OKAY, i == 3, i);
      end_read();
      total++;
      if (rd_q.size() - b_rd !== 4) begin bad++; $display("FAIL burst_beats: got %0d, required 4", rd_q.size() - b_rd); end
      else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (rd_q[b_rd + i] !== 32'hA5A5_0000 + i) begin
               bad++;
               $display("FAIL burst_data%0d: got %h, required %h", i, rd_q[b_rd + i], 32'hA5A5_0000 + i);
            end
         end
      end
      total++;
      if (rlast_cnt - b_rl !== 1 || rlast_idx !== b_rd + 4) begin
         bad++;
         $display("FAIL burst_rlast: count %0d at beat %0d, required 1 at %0d", rlast_cnt - b_rl, rlast_idx, b_rd + 4);
      end
      total++;
      if (rerr_cnt - b_re !== 0) begin bad++; $display("FAIL burst_rerr: got %0d, required 0", rerr_cnt - b_re); end
   endtask

   task automatic test_write;
      int b_wd, b_we;
      b_wd = wdone_cnt; b_we = werr_cnt;
      write_txn(32'h1000_0040, 32'h1234_5678, 4'b0011, 3, 0, OKAY);
      total++;
      if (wdone_cnt - b_wd !== 1) begin bad++; $display("FAIL write_done: got %0d, required 1", wdone_cnt - b_wd); end
      total++;
      if (werr_cnt - b_we !== 0) begin bad++; $display("FAIL write_err: got %0d, required 0", werr_cnt - b_we); end
      total++;
      if ({cap_awaddr, cap_awlen, cap_awsize, cap_awburst} !== {32'h1000_0040, 8'd0, 3'd2, 2'b01}) begin
         bad++;
         $display("FAIL write_aw: addr %h len %0d size %0d burst %b, required 10000040 0 2 01",
                  cap_awaddr, cap_awlen, cap_awsize, cap_awburst);
      end
      total++;
      if ({cap_wdata, cap_wstrb, cap_wlast} !== {32'h1234_5678, 4'b0011, 1'b1}) begin
         bad++;
         $display("FAIL write_w: data %h strb %b last %b, required 12345678 0011 1",
                  cap_wdata, cap_wstrb, cap_wlast);
      end
      write_txn(32'h1000_0080, 32'hCAFE_0001, 4'b1111, 0, 0, OKAY);
      write_txn(32'h1000_00C0, 32'hCAFE_0002, 4'b1100, 0, 2, OKAY);
      total++;
      if (wdone_cnt - b_wd !== 3) begin bad++; $display("FAIL write_done3: got %0d, required 3", wdone_cnt - b_wd); end
      total++;
      if (cap_wstrb !== 4'b1100 || cap_wdata !== 32'hCAFE_0002) begin
         bad++;
         $display("FAIL write_w3: data %h strb %b, required cafe0002 1100", cap_wdata, cap_wstrb);
      end
   endtask

   task automatic test_back_to_back;
      int b_ar, b_rd;
      b_ar = ar_hs; b_rd = rd_q.size();
      start_read(32'h0000_2000, 8'd0, 0);
      send_beat(32'h1111_1111, OKAY, 1'b1, 0);
      end_read();
      start_read(32'h0000_2004, 8'd0, 1);
      send_beat(32'h2222_2222, OKAY, 1'b1, 0);
      end_read();
      repeat (3) tick();
      total++;
      if (ar_hs - b_ar !== 2) begin bad++; $display("FAIL b2b_ar_hs: got %0d, required 2", ar_hs - b_ar); end
      total++;
      if (cap_araddr !== 32'h0000_2004) begin bad++; $display("FAIL b2b_addr: got %h, required 00002004", cap_araddr); end
      total++;
      if (rd_q.size() - b_rd !== 2) begin bad++; $display("FAIL b2b_beats: got %0d, required 2", rd_q.size() - b_rd); end
      else begin
         total++;
         if ({rd_q[b_rd], rd_q[b_rd + 1]} !== {32'h1111_1111, 32'h2222_2222}) begin
            bad++;
            $display("FAIL b2b_data: got %h %h, required 11111111 22222222", rd_q[b_rd], rd_q[b_rd + 1]);
         end
      end
   endtask

   task automatic test_errors;
      int b_re, b_rl, b_we, b_wd;
      b_re = rerr_cnt; b_rl = rlast_cnt; b_we = werr_cnt; b_wd = wdone_cnt;
      start_read(32'h0000_3000, 8'd1, 0);
      send_beat(32'h0000_0001, OKAY, 1'b0, 0);
      send_beat(32'h0000_0002, SLVERR, 1'b1, 1);
      end_read();
      total++;
      if (rerr_cnt - b_re !== 1) begin bad++; $display("FAIL err_slverr: rerr %0d, required 1", rerr_cnt - b_re); end
      // RLAST arrives after one beat of a two-beat burst: short burst must be flagged.
      start_read(32'h0000_3100, 8'd1, 0);
      send_beat(32'h0000_0003, OKAY, 1'b1, 0);
      end_read();
      total++;
      if (rerr_cnt - b_re !== 2) begin bad++; $display("FAIL err_short: rerr %0d, required 2", rerr_cnt - b_re); end
      // A clean read afterwards must not inherit the earlier error.
      start_read(32'h0000_3200, 8'd0, 0);
      send_beat(32'h0000_0004, OKAY, 1'b1, 0);
      end_read();
      total++;
      if (rerr_cnt - b_re !== 2 || rlast_cnt - b_rl !== 3) begin
         bad++;
         $display("FAIL err_clean: rerr %0d rlast %0d, required 2 3", rerr_cnt - b_re, rlast_cnt - b_rl);
      end
      write_txn(32'h1000_0100, 32'h0BAD_0BAD, 4'b1111, 1, 1, DECERR);
      total++;
      if (werr_cnt - b_we !== 1 || wdone_cnt - b_wd !== 1) begin
         bad++;
         $display("FAIL err_decerr: werr %0d done %0d, required 1 1", werr_cnt - b_we, wdone_cnt - b_wd);
      end
   endtask

   task automatic test_reset_midburst;
      int b_rd, b_rl, b_re;
      start_read(32'h0000_4000, 8'd3, 0);
      send_beat(32'h0000_00A0, OKAY, 1'b0, 0);
      send_beat(32'h0000_00A1, OKAY, 1'b0, 0);
      rst = 1'b1;
      arb_raddr_valid_i = 1'b0;
      axi_rvalid = 1'b1;
      tick();
      axi_rvalid = 1'b0;
      total++;
      if ({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} !== 5'b0) begin
         bad++;
         $display("FAIL midrst_axi: valid/ready = %b, required 00000",
                  {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready});
      end
      total++;
      if ({arb_rdata_ready_o, arb_rlast_o, arb_rerr_o} !== 3'b0 || arb_rdata_o !== 32'h0) begin
         bad++;
         $display("FAIL midrst_arb: pulses %b data %h, required 000 00000000",
                  {arb_rdata_ready_o, arb_rlast_o, arb_rerr_o}, arb_rdata_o);
      end
      rst = 1'b0;
      tick();
      tick();
      total++;
      if ({axi_arvalid, axi_rready} !== 2'b00) begin
         bad++;
         $display("FAIL midrst_idle: arvalid/rready = %b, required 00", {axi_arvalid, axi_rready});
      end
      b_rd = rd_q.size(); b_rl = rlast_cnt; b_re = rerr_cnt;
      start_read(32'h0000_4100, 8'd0, 0);
      send_beat(32'hCAFE_F00D, OKAY, 1'b1, 0);
      end_read();
      total++;
      if (rd_q.size() - b_rd !== 1 || rlast_cnt - b_rl !== 1 || rerr_cnt - b_re !== 0) begin
         bad++;
         $display("FAIL midrst_fresh: beats %0d rlast %0d rerr %0d, required 1 1 0",
                  rd_q.size() - b_rd, rlast_cnt - b_rl, rerr_cnt - b_re);
      end
      else begin
         total++;
         if (rd_q[b_rd] !== 32'hCAFE_F00D) begin
            bad++;
            $display("FAIL midrst_data: got %h, required cafef00d", rd_q[b_rd]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_burst_read();
      test_write();
      test_back_to_back();
      test_errors();
      test_reset_midburst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
